// File: rtl/pvr_setup_pkg.sv
// Shared definitions for the PVR plane-setup engine.
//   W_IN / W_MID / W_PROD : vertex, intermediate and full-product widths
//   MUL_STEPS             : products formed by the shared multiplier per triangle
//   FIXED_CYCLES          : handshake-to-out_valid cycles excluding the divide
//   setup_state_t         : sequencer state encoding
//   mul_shift()           : signed 32x32 product, >>> frac, truncated to W_MID
package pvr_setup_pkg;

    localparam int unsigned W_IN              = 32;
    localparam int unsigned W_MID             = 48;
    localparam int unsigned W_PROD            = 64;
    localparam int unsigned MUL_STEPS         = 6;
    localparam int unsigned DIV_ITERS_DEFAULT = 64;
    // DELTA(1) + MUL(6) + CROSS(1) + CMUL(2) + CSUB(1)
    localparam int unsigned FIXED_CYCLES      = 5 + MUL_STEPS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELTA = 3'd1,
        ST_MUL   = 3'd2,
        ST_CROSS = 3'd3,
        ST_DIV   = 3'd4,
        ST_CMUL  = 3'd5,
        ST_CSUB  = 3'd6,
        ST_DONE  = 3'd7
    } setup_state_t;

    function automatic int unsigned setup_latency(input int unsigned div_iters);
        return FIXED_CYCLES + div_iters;
    endfunction

    function automatic logic signed [W_MID-1:0] mul_shift(
        input logic signed [W_IN-1:0] a,
        input logic signed [W_IN-1:0] b,
        input logic [7:0]             frac
    );
        logic signed [W_PROD-1:0] p;
        p = (W_PROD'(a) * W_PROD'(b)) >>> frac;
        return W_MID'(p);
    endfunction

endpackage

// File: rtl/plane_div_serial.sv
// Serial signed restoring divider, one quotient bit per cycle.
//   clock, reset_n : clock, async active-low reset
//   i_start        : load operands and begin a W_DVD-cycle divide
//   i_dividend     : signed dividend (W_DVD bits)
//   i_divisor      : signed divisor (W_DVS bits), must be non-zero
//   o_quot         : low W_Q bits of the signed quotient, truncated toward zero
//   o_done         : high once the divide has finished, cleared by i_start
module plane_div_serial
#(
    parameter int unsigned W_DVD = 64,
    parameter int unsigned W_DVS = 48,
    parameter int unsigned W_Q   = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic signed [W_DVD-1:0] i_dividend,
    input  logic signed [W_DVS-1:0] i_divisor,
    output logic signed [W_Q-1:0]   o_quot,
    output logic                    o_done
);

    localparam int unsigned W_CNT = $clog2(W_DVD + 1);

    // r_dvd shifts the dividend magnitude out at the top while the quotient
    // bits shift in at the bottom; after W_DVD steps it holds the quotient.
    logic [W_DVD-1:0] r_dvd;
    logic [W_DVS-1:0] r_dvs;
    logic [W_DVS-1:0] r_rem;
    logic [W_CNT-1:0] r_cnt;
    logic             r_neg;
    logic             r_done;

    logic [W_DVD-1:0] w_dvd_mag;
    logic [W_DVS-1:0] w_dvs_mag;
    logic [W_DVS:0]   w_shift;
    logic [W_DVS:0]   w_rem_next;
    logic             w_fits;
    logic [W_DVD-1:0] w_q_signed;

    assign w_dvd_mag  = i_dividend[W_DVD-1] ? -i_dividend : i_dividend;
    assign w_dvs_mag  = i_divisor[W_DVS-1]  ? -i_divisor  : i_divisor;
    assign w_shift    = {r_rem, r_dvd[W_DVD-1]};
    assign w_fits     = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_fits ? (w_shift - {1'b0, r_dvs}) : w_shift;
    assign w_q_signed = r_neg ? -r_dvd : r_dvd;
    assign o_quot     = W_Q'(w_q_signed);
    assign o_done     = r_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_dvd  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_rem  <= '0;
            r_cnt  <= W_CNT'(W_DVD);
            r_neg  <= i_dividend[W_DVD-1] ^ i_divisor[W_DVS-1];
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= W_DVS'(w_rem_next);
            r_dvd  <= {r_dvd[W_DVD-2:0], w_fits};
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == W_CNT'(1));
        end
    end

endmodule

// File: rtl/plane_setup_seq.sv
// Sequential triangle plane-setup engine: from one vertex triple computes
// fddx, fddy, small_c such that Z = x*fddx + y*fddy + small_c.
//   clock, reset_n        : clock, async active-low reset
//   frac_bits             : fixed-point fraction bits, captured at accept
//   in_valid / in_ready   : vertex triple handshake (in_ready = idle)
//   fx1..fz3              : signed fixed-point vertex X, Y, Z
//   out_valid / out_ready : coefficient handshake
//   fddx, fddy, small_c   : plane coefficients
//   degenerate            : zero-area triangle, qualified by out_valid
//   busy                  : engine not idle
module plane_setup_seq
    import pvr_setup_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             frac_bits,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [W_IN-1:0] fx1,
    input  logic signed [W_IN-1:0] fx2,
    input  logic signed [W_IN-1:0] fx3,
    input  logic signed [W_IN-1:0] fy1,
    input  logic signed [W_IN-1:0] fy2,
    input  logic signed [W_IN-1:0] fy3,
    input  logic signed [W_IN-1:0] fz1,
    input  logic signed [W_IN-1:0] fz2,
    input  logic signed [W_IN-1:0] fz3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [W_IN-1:0] fddx,
    output logic signed [W_IN-1:0] fddy,
    output logic signed [W_IN-1:0] small_c,
    output logic                   degenerate,
    output logic                   busy
);

    localparam int unsigned W_CNT = $clog2(DIV_ITERS + 1);
    localparam logic [W_CNT-1:0] MUL_LAST = W_CNT'(MUL_STEPS - 1);
    localparam logic [W_CNT-1:0] DIV_LAST = W_CNT'(DIV_ITERS - 1);

    setup_state_t            r_state;
    logic [W_CNT-1:0]        r_cnt;
    logic [7:0]              r_frac;
    logic signed [W_IN-1:0]  r_x1, r_x2, r_x3, r_y1, r_y2, r_y3, r_z1, r_z2, r_z3;
    logic signed [W_IN-1:0]  r_dx2, r_dx3, r_dy2, r_dy3, r_dz2, r_dz3;
    logic signed [W_MID-1:0] r_p [MUL_STEPS];
    logic                    r_degen_w;
    logic signed [W_IN-1:0]  r_qx, r_qy, r_t0, r_t1;
    logic signed [W_IN-1:0]  r_fddx, r_fddy, r_c;
    logic                    r_degen;

    logic signed [W_IN-1:0]      w_ma, w_mb;
    logic signed [W_MID-1:0]     w_prod;
    logic signed [W_MID-1:0]     w_aa, w_ba, w_c;
    logic signed [DIV_ITERS-1:0] w_dvd_x, w_dvd_y;
    logic                        w_div_start;
    logic signed [W_IN-1:0]      w_qx, w_qy, w_qx_sel, w_qy_sel;
    logic                        w_dx_done, w_dy_done;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign fddx       = r_fddx;
    assign fddy       = r_fddy;
    assign small_c    = r_c;
    assign degenerate = r_degen;

    // Products arrive through a shift chain, so after MUL r_p[0] holds the first.
    assign w_aa = r_p[0] - r_p[1];
    assign w_ba = r_p[2] - r_p[3];
    assign w_c  = r_p[4] - r_p[5];

    assign w_dvd_x     = DIV_ITERS'(w_aa) <<< r_frac;
    assign w_dvd_y     = DIV_ITERS'(w_ba) <<< r_frac;
    assign w_div_start = (r_state == ST_CROSS) && (w_c != '0);

    // A zero divisor never starts the dividers; their stale results are masked.
    assign w_qx_sel = (r_degen_w || !w_dx_done) ? '0 : w_qx;
    assign w_qy_sel = (r_degen_w || !w_dy_done) ? '0 : w_qy;

    always_comb begin
        w_ma = '0;
        w_mb = '0;
        if (r_state == ST_MUL) begin
            case (r_cnt)
                W_CNT'(0): begin w_ma = r_dz3; w_mb = r_dy2; end
                W_CNT'(1): begin w_ma = r_dz2; w_mb = r_dy3; end
                W_CNT'(2): begin w_ma = r_dx3; w_mb = r_dz2; end
                W_CNT'(3): begin w_ma = r_dx2; w_mb = r_dz3; end
                W_CNT'(4): begin w_ma = r_dx3; w_mb = r_dy2; end
                default:   begin w_ma = r_dx2; w_mb = r_dy3; end
            endcase
        end else if (r_state == ST_CMUL) begin
            if (r_cnt == '0) begin
                w_ma = w_qx_sel;
                w_mb = r_x1;
            end else begin
                w_ma = r_qy;
                w_mb = r_y1;
            end
        end
    end

    assign w_prod = mul_shift(w_ma, w_mb, r_frac);

    plane_div_serial #(
        .W_DVD (DIV_ITERS),
        .W_DVS (W_MID),
        .W_Q   (W_IN)
    ) u_div_x (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_start    (w_div_start),
        .i_dividend (w_dvd_x),
        .i_divisor  (w_c),
        .o_quot     (w_qx),
        .o_done     (w_dx_done)
    );

    plane_div_serial #(
        .W_DVD (DIV_ITERS),
        .W_DVS (W_MID),
        .W_Q   (W_IN)
    ) u_div_y (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_start    (w_div_start),
        .i_dividend (w_dvd_y),
        .i_divisor  (w_c),
        .o_quot     (w_qy),
        .o_done     (w_dy_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_frac    <= '0;
            r_x1 <= '0; r_x2 <= '0; r_x3 <= '0;
            r_y1 <= '0; r_y2 <= '0; r_y3 <= '0;
            r_z1 <= '0; r_z2 <= '0; r_z3 <= '0;
            r_dx2 <= '0; r_dx3 <= '0; r_dy2 <= '0;
            r_dy3 <= '0; r_dz2 <= '0; r_dz3 <= '0;
            for (int unsigned i = 0; i < MUL_STEPS; i++) r_p[i] <= '0;
            r_degen_w <= 1'b0;
            r_qx      <= '0;
            r_qy      <= '0;
            r_t0      <= '0;
            r_t1      <= '0;
            r_fddx    <= '0;
            r_fddy    <= '0;
            r_c       <= '0;
            r_degen   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_frac <= frac_bits;
                        r_x1 <= fx1; r_x2 <= fx2; r_x3 <= fx3;
                        r_y1 <= fy1; r_y2 <= fy2; r_y3 <= fy3;
                        r_z1 <= fz1; r_z2 <= fz2; r_z3 <= fz3;
                        r_state <= ST_DELTA;
                    end
                end
                ST_DELTA: begin
                    r_dx2   <= r_x2 - r_x1;
                    r_dx3   <= r_x3 - r_x1;
                    r_dy2   <= r_y2 - r_y1;
                    r_dy3   <= r_y3 - r_y1;
                    r_dz2   <= r_z2 - r_z1;
                    r_dz3   <= r_z3 - r_z1;
                    r_cnt   <= '0;
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    for (int unsigned i = 0; i < MUL_STEPS - 1; i++) r_p[i] <= r_p[i+1];
                    r_p[MUL_STEPS-1] <= w_prod;
                    if (r_cnt == MUL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_CROSS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CROSS: begin
                    r_degen_w <= (w_c == '0);
                    r_cnt     <= '0;
                    r_state   <= ST_DIV;
                end
                ST_DIV: begin
                    // Counted even when the divide is bypassed to keep latency fixed.
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_CMUL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CMUL: begin
                    if (r_cnt == '0) begin
                        r_qx  <= w_qx_sel;
                        r_qy  <= w_qy_sel;
                        r_t0  <= W_IN'(w_prod);
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_t1    <= W_IN'(w_prod);
                        r_cnt   <= '0;
                        r_state <= ST_CSUB;
                    end
                end
                ST_CSUB: begin
                    r_fddx  <= r_qx;
                    r_fddy  <= r_qy;
                    r_c     <= r_z1 - r_t0 - r_t1;
                    r_degen <= r_degen_w;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
